// File: rtl/regwr_decoder_if.sv
// Bus bundle for regwr_decoder: per-port write requests, lock control and
// the decoded/status outputs. clk and rst stay outside as plain ports.
interface regwr_decoder_if #(
  parameter int ADDR_W = 4,
  parameter int PORTS  = 2
);
  localparam int NREG = 1 << ADDR_W;

  logic [PORTS-1:0]        wr_en;
  logic [PORTS*ADDR_W-1:0] wr_addr;
  logic                    lock_set;
  logic                    lock_clr;
  logic [ADDR_W-1:0]       lock_addr;
  logic [NREG-1:0]         wr_onehot;
  logic [NREG-1:0]         lock_mask;
  logic                    conflict;
  logic                    blocked;
  logic [7:0]              wr_cnt;

  // Requester side: drives writes and lock requests, observes status.
  modport master (
    output wr_en, wr_addr, lock_set, lock_clr, lock_addr,
    input  wr_onehot, lock_mask, conflict, blocked, wr_cnt
  );

  // Decoder side.
  modport slave (
    input  wr_en, wr_addr, lock_set, lock_clr, lock_addr,
    output wr_onehot, lock_mask, conflict, blocked, wr_cnt
  );
endinterface

// File: rtl/regwr_decoder.sv
// regwr_decoder: multi-port register write decoder with per-register locks.
// Each enabled port is decoded one-hot, the results are ORed, locked
// registers are masked off and the vector is registered (one cycle latency).
// Also flags same-address collisions (conflict), lock suppression (blocked)
// and counts cycles with a non-zero registered write vector (wr_cnt, wraps).
// Optional feature: define ZERO_REG_PROTECT_EN to make register 0 permanently
// locked (writes to it pulse blocked, lock requests to it are ignored).
module regwr_decoder #(
  parameter int ADDR_W = 4,
  parameter int PORTS  = 2
) (
  input  logic            clk,
  input  logic            rst,
  regwr_decoder_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [NREG-1:0] LP_ONE = NREG'(1);

  // Register 0 appears permanently locked when protection is built in.
`ifdef ZERO_REG_PROTECT_EN
  localparam logic [NREG-1:0] LP_FIXED_LOCK = NREG'(1);
`else
  localparam logic [NREG-1:0] LP_FIXED_LOCK = '0;
`endif

  logic [PORTS-1:0][NREG-1:0] w_dec;
  logic [NREG-1:0]            w_hit;
  logic [NREG-1:0]            w_lock_eff;
  logic [NREG-1:0]            w_allow;
  logic                       w_blocked;
  logic                       w_conflict;
  logic [NREG-1:0]            w_lock_next;

  logic [NREG-1:0]            r_onehot;
  logic [NREG-1:0]            r_lock;
  logic                       r_conflict;
  logic                       r_blocked;
  logic [7:0]                 r_cnt;

  // Per-port one-hot address decode, gated by that port's enable.
  generate
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_dec
      assign w_dec[gi] = bus.wr_en[gi]
                       ? (LP_ONE << bus.wr_addr[gi*ADDR_W +: ADDR_W])
                       : '0;
    end
  endgenerate

  // Merge all ports; a shared address collapses to a single set bit.
  always_comb begin
    w_hit = '0;
    for (int p = 0; p < PORTS; p++) begin
      w_hit = w_hit | w_dec[p];
    end
  end

  // Detect two or more enabled ports carrying the same address.
  always_comb begin
    w_conflict = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      for (int q = p + 1; q < PORTS; q++) begin
        if (bus.wr_en[p] && bus.wr_en[q] &&
            (bus.wr_addr[p*ADDR_W +: ADDR_W] == bus.wr_addr[q*ADDR_W +: ADDR_W])) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  // Writes are checked against the current (old) mask, so a lock_set in
  // the same cycle as a write does not suppress that write.
  assign w_lock_eff = r_lock | LP_FIXED_LOCK;
  assign w_allow    = w_hit & ~w_lock_eff;
  assign w_blocked  = |(w_hit & w_lock_eff);

  // Next lock state: set takes priority over clear on the same address.
  always_comb begin
    w_lock_next = r_lock;
    if (bus.lock_set) begin
      w_lock_next[bus.lock_addr] = 1'b1;
    end else if (bus.lock_clr) begin
      w_lock_next[bus.lock_addr] = 1'b0;
    end
    // The stored bit for a fixed-locked register never changes.
    w_lock_next = w_lock_next & ~LP_FIXED_LOCK;
  end

  // Register decoded writes, status pulses and lock state; reset drops any
  // in-flight decode and ignores requests presented during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_onehot   <= '0;
      r_lock     <= '0;
      r_conflict <= 1'b0;
      r_blocked  <= 1'b0;
    end else begin
      r_onehot   <= w_allow;
      r_lock     <= w_lock_next;
      r_conflict <= w_conflict;
      r_blocked  <= w_blocked;
    end
  end

  // Count cycles whose registered write vector was non-zero; wraps at 256.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + {7'd0, |r_onehot};
    end
  end

  assign bus.wr_onehot = r_onehot;
  assign bus.lock_mask = r_lock | LP_FIXED_LOCK;
  assign bus.conflict  = r_conflict;
  assign bus.blocked   = r_blocked;
  assign bus.wr_cnt    = r_cnt;

endmodule

// File: tb/tb_regwr_decoder.sv
// Scoreboard bench for regwr_decoder (ADDR_W=4, PORTS=2). The driver applies
// one directed vector per cycle on the falling edge and queues the expected
// outputs for the following rising edge; a monitor pops and compares.
module tb_regwr_decoder;
  logic clk;
  logic rst;

  regwr_decoder_if #(.ADDR_W(4), .PORTS(2)) bus ();

  regwr_decoder #(.ADDR_W(4), .PORTS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef ZERO_REG_PROTECT_EN
  localparam logic ZP = 1'b1;
`else
  localparam logic ZP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [15:0] onehot;
    logic [15:0] lock;
    logic        conf;
    logic        blk;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] m_lock;      // expected stored lock state
  logic [15:0] m_prev_oh;   // expected wr_onehot after the previous edge
  logic [7:0]  m_cnt;       // expected wr_cnt

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", name, field, act, exp);
    end
  endtask

  // Monitor: checks every registered output one step after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.name, "wr_onehot", 32'(bus.wr_onehot), 32'(e.onehot));
        chk(e.name, "lock_mask", 32'(bus.lock_mask), 32'(e.lock));
        chk(e.name, "conflict",  32'(bus.conflict),  32'(e.conf));
        chk(e.name, "blocked",   32'(bus.blocked),   32'(e.blk));
        chk(e.name, "wr_cnt",    32'(bus.wr_cnt),    32'(e.cnt));
        $display("txn %-10s oh=%04h lock=%04h conf=%0b blk=%0b cnt=%0d",
                 e.name, bus.wr_onehot, bus.lock_mask, bus.conflict,
                 bus.blocked, bus.wr_cnt);
      end
    end
  end

  // Drive one cycle's inputs and queue the outputs expected after the edge.
  task automatic step(input string name, input logic r, input logic [1:0] en,
                      input logic [3:0] a0, input logic [3:0] a1,
                      input logic ls, input logic lc, input logic [3:0] la,
                      input logic [15:0] e_oh, input logic e_conf,
                      input logic e_blk);
    exp_t e;
    @(negedge clk);
    rst           = r;
    bus.wr_en     = en;
    bus.wr_addr   = {a1, a0};
    bus.lock_set  = ls;
    bus.lock_clr  = lc;
    bus.lock_addr = la;
    e.name = name;
    if (r) begin
      m_lock    = '0;
      m_cnt     = 8'd0;
      e.onehot  = '0;
      e.conf    = 1'b0;
      e.blk     = 1'b0;
    end else begin
      m_cnt = m_cnt + ((m_prev_oh != 16'd0) ? 8'd1 : 8'd0);
      if (ls && !(ZP && la == 4'd0)) m_lock[la] = 1'b1;
      else if (lc && !ls && !(ZP && la == 4'd0)) m_lock[la] = 1'b0;
      e.onehot = e_oh;
      e.conf   = e_conf;
      e.blk    = e_blk;
    end
    e.lock    = m_lock | {15'd0, ZP};
    e.cnt     = m_cnt;
    m_prev_oh = e.onehot;
    sb_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = '0; bus.wr_addr = '0;
    bus.lock_set = 1'b0; bus.lock_clr = 1'b0; bus.lock_addr = '0;
    m_lock = '0; m_prev_oh = '0; m_cnt = 8'd0;

    // Reset: requests presented during reset are ignored.
    step("rst0", 1, 2'b00, 4'd0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 0);
    step("rst_wr", 1, 2'b11, 4'd2, 4'd2, 1, 0, 4'd3, 16'h0000, 0, 0);
    step("idle0", 0, 2'b00, 4'd0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 0);

    // Single-port sweep of all addresses.
    for (int a = 0; a < 16; a++) begin
      if (ZP && a == 0)
        step("sweep", 0, 2'b01, 4'(a), 4'd0, 0, 0, 4'd0, 16'h0000, 0, 1);
      else
        step("sweep", 0, 2'b01, 4'(a), 4'd0, 0, 0, 4'd0, 16'h0001 << a, 0, 0);
    end
    step("sweep_end", 0, 2'b00, 4'd0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 0);

    // Dual-port: distinct addresses, then identical addresses.
    step("dual", 0, 2'b11, 4'd3, 4'd12, 0, 0, 4'd0, 16'h1008, 0, 0);
    step("same", 0, 2'b11, 4'd5, 4'd5, 0, 0, 4'd0, 16'h0020, 1, 0);
    step("post_same", 0, 2'b00, 4'd0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 0);
    step("p1_only", 0, 2'b10, 4'd5, 4'd14, 0, 0, 4'd0, 16'h4000, 0, 0);

    // Locking.
    step("lock7", 0, 2'b00, 4'd0, 4'd0, 1, 0, 4'd7, 16'h0000, 0, 0);
    step("wr_lock7", 0, 2'b01, 4'd7, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 1);
    step("setclr7", 0, 2'b00, 4'd0, 4'd0, 1, 1, 4'd7, 16'h0000, 0, 0);
    step("part_blk", 0, 2'b11, 4'd7, 4'd2, 0, 0, 4'd0, 16'h0004, 0, 1);
    step("clr7", 0, 2'b00, 4'd0, 4'd0, 0, 1, 4'd7, 16'h0000, 0, 0);
    step("wr_unlk7", 0, 2'b01, 4'd7, 4'd0, 0, 0, 4'd0, 16'h0080, 0, 0);
    step("setclr7b", 0, 2'b00, 4'd0, 4'd0, 1, 1, 4'd7, 16'h0000, 0, 0);
    step("lock0", 0, 2'b00, 4'd0, 4'd0, 1, 0, 4'd0, 16'h0000, 0, 0);
    if (ZP)
      step("wr0", 0, 2'b01, 4'd0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 1);
    else
      step("wr0", 0, 2'b01, 4'd0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 1);

    // Lock race: write decoded against the old mask.
    step("race9", 0, 2'b01, 4'd9, 4'd0, 1, 0, 4'd9, 16'h0200, 0, 0);
    step("wr_lock9", 0, 2'b10, 4'd0, 4'd9, 0, 0, 4'd0, 16'h0000, 0, 1);

    // Counter wrap: 256 write cycles from a cleared counter.
    step("rst_wrap", 1, 2'b00, 4'd0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 0);
    for (int i = 0; i < 256; i++) begin
      step("wrap", 0, 2'b01, 4'd3, 4'd0, 0, 0, 4'd0, 16'h0008, 0, 0);
    end
    step("wrap_end", 0, 2'b00, 4'd0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 0);

    // Reset in the middle of traffic.
    step("lock4", 0, 2'b01, 4'd5, 4'd0, 1, 0, 4'd4, 16'h0020, 0, 0);
    step("rst_mid", 1, 2'b11, 4'd6, 4'd6, 1, 0, 4'd8, 16'h0000, 0, 0);
    step("post_rst", 0, 2'b00, 4'd0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 0);
    step("unlocked", 0, 2'b11, 4'd4, 4'd8, 0, 0, 4'd0, 16'h0110, 0, 0);
    step("tail", 0, 2'b00, 4'd0, 4'd0, 0, 0, 4'd0, 16'h0000, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #3;
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regwr_decoder.md
REGWR_DECODER -- requirements
Module: regwr_decoder

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 4, meaning the register address width; there are NREG = 2**ADDR_W registers.
REQ-002 The block SHALL take parameter PORTS, default 2, meaning the number of write ports; legal range is 1..4.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 Port wr_en SHALL be an input, PORTS bits wide: per-port write request.
REQ-006 Port wr_addr SHALL be an input, PORTS*ADDR_W bits wide: per-port address; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-007 Port lock_set SHALL be an input, 1 bit wide: request to set the lock bit selected by lock_addr.
REQ-008 Port lock_clr SHALL be an input, 1 bit wide: request to clear the lock bit selected by lock_addr.
REQ-009 Port lock_addr SHALL be an input, ADDR_W bits wide: lock target.
REQ-010 Port wr_onehot SHALL be an output, NREG bits wide: registered write-enable vector.
REQ-011 Port lock_mask SHALL be an output, NREG bits wide: current lock state.
REQ-012 Port conflict SHALL be an output, 1 bit wide: one-cycle pulse on a same-address multi-port write.
REQ-013 Port blocked SHALL be an output, 1 bit wide: one-cycle pulse when any write is suppressed by a lock.
REQ-014 Port wr_cnt SHALL be an output, 8 bits wide: count of cycles with at least one non-zero wr_onehot.

Function
REQ-015 wr_onehot SHALL have exactly one cycle of latency: in cycle N+1, bit i is set iff, in cycle N, some port p had wr_en[p]=1, addr_p==i, and lock_mask[i]=0.
REQ-016 Distinct enabled addresses SHALL produce multiple set bits in wr_onehot; address decoding itself is strictly one-hot per port.
REQ-017 conflict SHALL be 1 in cycle N+1 iff, in cycle N, two or more enabled ports carried an identical address; the corresponding wr_onehot bit is still set once.
REQ-018 blocked SHALL be 1 in cycle N+1 iff, in cycle N, at least one enabled port targeted a locked register.
REQ-019 lock_mask SHALL update one cycle after lock_set or lock_clr; a write in the same cycle as a lock_set is decoded against the old mask.
REQ-020 If lock_set and lock_clr are both asserted in the same cycle, set SHALL win.
REQ-021 wr_cnt SHALL increment by 1 in the cycle after a non-zero wr_onehot is registered, and SHALL wrap from 255 to 0.
REQ-022 With all wr_en=0, wr_onehot, conflict and blocked SHALL be 0 on the next cycle.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL clear wr_onehot, lock_mask, conflict, blocked and wr_cnt to 0.
REQ-024 While rst=1, the block SHALL ignore writes and lock requests presented in that cycle.
REQ-025 Reset asserted mid-operation SHALL discard any in-flight decode, so that wr_onehot is 0 in the cycle after the reset edge.

Configuration
REQ-026 Macro ZERO_REG_PROTECT_EN SHALL control protection of register 0.
REQ-027 With ZERO_REG_PROTECT_EN defined, wr_onehot[0] SHALL be held at 0 permanently, and a write to address 0 SHALL pulse blocked.
REQ-028 With ZERO_REG_PROTECT_EN defined, lock requests to address 0 SHALL have no effect, and lock_mask[0] SHALL read 1.
REQ-029 Without ZERO_REG_PROTECT_EN, register 0 SHALL behave like every other register.

Verification
REQ-030 Sweep: single port, addresses 0..15, one per cycle -> wr_onehot = 1<<addr one cycle later; wr_cnt ends at 16 (or 15 with the macro, and blocked pulsing on addr 0).
REQ-031 Dual write: port0=3, port1=12 -> wr_onehot=16'h1008, conflict=0; then port0=port1=5 -> wr_onehot=16'h0020, conflict=1 for one cycle.
REQ-032 Lock: lock_set addr 7, then write addr 7 -> wr_onehot=0, blocked=1; lock_set and lock_clr together on addr 7 -> lock_mask[7] stays 1.
REQ-033 Lock race: lock_set addr 9 and write 9 in the same cycle -> wr_onehot=16'h0200; a second write to 9 next cycle -> blocked=1.
REQ-034 Wrap/reset: 256 write cycles -> wr_cnt=0; rst asserted during a write -> all outputs 0 on the next cycle, lock_mask cleared.
